// File: rtl/esm_entry_buffer_if.sv
// Handshake bundle for the entry buffer: upstream write port, selection-core
// request port, downstream emit port and status.
interface esm_entry_buffer_if #(
    parameter int bs = 16,
    parameter int dw = 8
);
    localparam int bs_bits = $clog2(bs);

    logic                 in_valid;
    logic [dw-1:0]        in_data;
    logic                 in_ready;
    logic                 ready_valid;
    logic [bs_bits-1:0]   ready_index;
    logic                 sel_valid;
    logic [bs_bits-1:0]   sel_index;
    logic                 sel_ready;
    logic                 out_valid;
    logic [dw-1:0]        out_data;
    logic                 out_ready;
    logic [bs_bits:0]     occupancy;
    logic                 sel_err;

    // Environment side: drives payload, selects and downstream ready.
    modport master (
        output in_valid, in_data, sel_valid, sel_index, out_ready,
        input  in_ready, ready_valid, ready_index, sel_ready,
               out_valid, out_data, occupancy, sel_err
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_data, sel_valid, sel_index, out_ready,
        output in_ready, ready_valid, ready_index, sel_ready,
               out_valid, out_data, occupancy, sel_err
    );
endinterface

// File: rtl/esm_entry_buffer.sv
// Entry buffer: stores incoming entries in the lowest free slot, announces the
// slot index to the selection core, and emits whichever slot the core selects.
//
// Output stage states:
//   state   | meaning
//   S_EMPTY | no emitted entry pending, out_valid = 0
//   S_HOLD  | out_data holds an emitted entry, out_valid = 1
module esm_entry_buffer #(
    parameter int bs = 16,
    parameter int dw = 8
) (
    input  logic             clk,
    input  logic             rst,
    esm_entry_buffer_if.slave bus
);
    localparam int bs_bits = $clog2(bs);
    localparam logic [bs_bits:0] FULL_COUNT = (bs_bits + 1)'(bs);
    localparam logic [bs_bits:0] ONE_COUNT  = (bs_bits + 1)'(1);
    localparam logic [bs-1:0]    ONE_HOT    = {{(bs - 1){1'b0}}, 1'b1};

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    logic [dw-1:0]      r_mem [bs];
    logic [bs-1:0]      r_occ;
    logic [bs_bits:0]   r_count;
    state_t             r_state;
    logic               r_out_valid;
    logic [dw-1:0]      r_out_data;
    logic               r_ready_valid;
    logic [bs_bits-1:0] r_ready_index;
    logic               r_sel_err;

    logic               w_in_ready;
    logic               w_sel_ready;
    logic               w_wr_fire;
    logic               w_sel_fire;
    logic               w_sel_hit;
    logic               w_sel_miss;
    logic [bs_bits-1:0] w_free_idx;
    logic [bs-1:0]      w_set_mask;
    logic [bs-1:0]      w_clr_mask;

    assign w_in_ready  = (r_count != FULL_COUNT);
    assign w_sel_ready = !r_out_valid || bus.out_ready;
    assign w_wr_fire   = bus.in_valid && w_in_ready;
    assign w_sel_fire  = bus.sel_valid && w_sel_ready;
    // A hit is decided on the pre-edge bitmap, so a slot freed this cycle is
    // never a write candidate until the following cycle.
    assign w_sel_hit   = w_sel_fire && r_occ[bus.sel_index];
    assign w_sel_miss  = w_sel_fire && !r_occ[bus.sel_index];
    assign w_set_mask  = w_wr_fire ? (ONE_HOT << w_free_idx) : '0;
    assign w_clr_mask  = w_sel_hit ? (ONE_HOT << bus.sel_index) : '0;

    // Lowest-index free slot of the current bitmap.
    always_comb begin
        w_free_idx = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (!r_occ[i]) begin
                w_free_idx = bs_bits'(i);
            end
        end
    end

    // Slot payload storage; contents are don't-care until the slot is written.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_free_idx] <= bus.in_data;
        end
    end

    // Occupied bitmap and fill count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ   <= '0;
            r_count <= '0;
        end else begin
            r_occ <= (r_occ | w_set_mask) & ~w_clr_mask;
            case ({w_wr_fire, w_sel_hit})
                2'b10:   r_count <= r_count + ONE_COUNT;
                2'b01:   r_count <= r_count - ONE_COUNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // Write-announce and empty-select error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready_valid <= 1'b0;
            r_ready_index <= '0;
            r_sel_err     <= 1'b0;
        end else begin
            r_ready_valid <= w_wr_fire;
            if (w_wr_fire) begin
                r_ready_index <= w_free_idx;
            end
            r_sel_err <= w_sel_miss;
        end
    end

    // Output stage FSM with registered out_valid/out_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_sel_hit) begin
                        r_state     <= S_HOLD;
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_mem[bus.sel_index];
                    end
                end
                S_HOLD: begin
                    if (w_sel_hit) begin
                        r_out_data <= r_mem[bus.sel_index];
                    end else if (bus.out_ready) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.sel_ready   = w_sel_ready;
    assign bus.ready_valid = r_ready_valid;
    assign bus.ready_index = r_ready_index;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.occupancy   = r_count;
    assign bus.sel_err     = r_sel_err;
endmodule

// File: tb/tb_esm_entry_buffer.sv
// Testbench for esm_entry_buffer: directed scenarios plus randomized traffic,
// compared against a slot-array model of the buffer.
module tb_esm_entry_buffer;
    localparam int BS = 16;
    localparam int DW = 8;
    localparam int BB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    esm_entry_buffer_if #(.bs(BS), .dw(DW)) bus ();
    esm_entry_buffer #(.bs(BS), .dw(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Reference model state.
    logic [DW-1:0] m_mem [BS];
    bit            m_occ [BS];
    int            m_cnt;
    bit            m_ov;
    logic [DW-1:0] m_od;
    bit            e_rv;
    logic [BB-1:0] e_ri;
    bit            e_err;
    bit            e_in_ready;
    bit            e_sel_ready;
    logic          obs_in_ready;
    logic          obs_sel_ready;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        for (int i = 0; i < BS; i++) m_occ[i] = 1'b0;
        m_cnt = 0;
        m_ov  = 1'b0;
        m_od  = '0;
        e_rv  = 1'b0;
        e_ri  = '0;
        e_err = 1'b0;
    endtask

    task automatic set_idle();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sel_valid = 1'b0;
        bus.sel_index = '0;
        bus.out_ready = 1'b1;
    endtask

    // Drives one clock cycle of inputs and advances the model across the edge.
    task automatic drive_cycle(input bit iv, input logic [DW-1:0] id,
                               input bit sv, input logic [BB-1:0] si, input bit ordy);
        bit wr, sf, hit;
        int k;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.sel_valid = sv;
        bus.sel_index = si;
        bus.out_ready = ordy;
        #1;
        obs_in_ready  = bus.in_ready;
        obs_sel_ready = bus.sel_ready;
        e_in_ready    = (m_cnt != BS);
        e_sel_ready   = !m_ov || ordy;
        @(posedge clk);
        wr  = iv && e_in_ready;
        sf  = sv && e_sel_ready;
        hit = sf && m_occ[si];
        k   = 0;
        if (wr) begin
            k = -1;
            for (int i = BS - 1; i >= 0; i--) if (!m_occ[i]) k = i;
            m_mem[k] = id;
            m_occ[k] = 1'b1;
            m_cnt++;
        end
        if (hit) begin
            m_od      = m_mem[si];
            m_occ[si] = 1'b0;
            m_cnt--;
            m_ov      = 1'b1;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        e_err = sf && !hit;
        e_rv  = wr;
        if (wr) e_ri = BB'(k);
        #1;
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b0;
        #12;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        n_checks++; if (bus.occupancy !== '0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
        n_checks++; if (bus.ready_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ready_valid got %0b want 0", bus.ready_valid); end
        n_checks++; if (bus.ready_index !== '0) begin n_fail++; $display("FAIL reset_ready_index got %0d want 0", bus.ready_index); end
        n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got %0b want 0", bus.sel_err); end
        n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", bus.out_data); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_fill();
        for (int i = 0; i < BS; i++) begin
            drive_cycle(1'b1, DW'(8'hA0 + i), 1'b0, '0, 1'b1);
            n_checks++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[%0d] got %0b want 1", i, obs_in_ready); end
            n_checks++; if (bus.ready_valid !== 1'b1) begin n_fail++; $display("FAIL fill_ready_valid[%0d] got %0b want 1", i, bus.ready_valid); end
            n_checks++; if (bus.ready_index !== BB'(i)) begin n_fail++; $display("FAIL fill_ready_index got %0d want %0d", bus.ready_index, i); end
        end
        drive_cycle(1'b0, '0, 1'b0, '0, 1'b1);
        n_checks++; if (bus.ready_valid !== 1'b0) begin n_fail++; $display("FAIL fill_pulse_end got %0b want 0", bus.ready_valid); end
        n_checks++; if (bus.occupancy !== 5'd16) begin n_fail++; $display("FAIL fill_occupancy got %0d want 16", bus.occupancy); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_in_ready got %0b want 0", bus.in_ready); end
    endtask

    task automatic test_select_backpressure();
        drive_cycle(1'b0, '0, 1'b1, 4'd5, 1'b0);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got %0b want 1", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'hA5) begin n_fail++; $display("FAIL bp_out_data got %0h want a5", bus.out_data); end
        n_checks++; if (bus.occupancy !== 5'd15) begin n_fail++; $display("FAIL bp_occupancy got %0d want 15", bus.occupancy); end
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b0, '0, 1'b1, 4'd6, 1'b0);
            n_checks++; if (obs_sel_ready !== 1'b0) begin n_fail++; $display("FAIL bp_sel_ready got %0b want 0", obs_sel_ready); end
            n_checks++; if (bus.out_data !== 8'hA5) begin n_fail++; $display("FAIL bp_hold_data got %0h want a5", bus.out_data); end
            n_checks++; if (bus.occupancy !== 5'd15) begin n_fail++; $display("FAIL bp_hold_occ got %0d want 15", bus.occupancy); end
        end
        drive_cycle(1'b0, '0, 1'b0, '0, 1'b1);
        n_checks++; if (obs_sel_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b want 1", obs_sel_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_simultaneous();
        drive_cycle(1'b1, 8'h55, 1'b0, '0, 1'b1);
        n_checks++; if (bus.ready_index !== 4'd5) begin n_fail++; $display("FAIL simul_refill_index got %0d want 5", bus.ready_index); end
        drive_cycle(1'b1, 8'h11, 1'b1, 4'd3, 1'b1);
        n_checks++; if (obs_in_ready !== 1'b0) begin n_fail++; $display("FAIL simul_full_in_ready got %0b want 0", obs_in_ready); end
        n_checks++; if (bus.ready_valid !== 1'b0) begin n_fail++; $display("FAIL simul_refused got %0b want 0", bus.ready_valid); end
        n_checks++; if (bus.out_data !== 8'hA3) begin n_fail++; $display("FAIL simul_emit got %0h want a3", bus.out_data); end
        n_checks++; if (bus.occupancy !== 5'd15) begin n_fail++; $display("FAIL simul_occ got %0d want 15", bus.occupancy); end
        drive_cycle(1'b1, 8'h11, 1'b0, '0, 1'b1);
        n_checks++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_in_ready_back got %0b want 1", obs_in_ready); end
        n_checks++; if (bus.ready_valid !== 1'b1 || bus.ready_index !== 4'd3) begin n_fail++; $display("FAIL simul_slot got v=%0b idx=%0d want v=1 idx=3", bus.ready_valid, bus.ready_index); end
        drive_cycle(1'b0, '0, 1'b1, 4'd3, 1'b1);
        n_checks++; if (bus.out_data !== 8'h11) begin n_fail++; $display("FAIL simul_readback got %0h want 11", bus.out_data); end
    endtask

    task automatic test_empty_select();
        apply_reset();
        drive_cycle(1'b0, '0, 1'b1, 4'd7, 1'b1);
        n_checks++; if (bus.sel_err !== 1'b1) begin n_fail++; $display("FAIL empty_sel_err got %0b want 1", bus.sel_err); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_out_valid got %0b want 0", bus.out_valid); end
        n_checks++; if (bus.occupancy !== '0) begin n_fail++; $display("FAIL empty_occ got %0d want 0", bus.occupancy); end
        drive_cycle(1'b0, '0, 1'b0, '0, 1'b1);
        n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL empty_err_pulse got %0b want 0", bus.sel_err); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wd [10];
        logic [BB-1:0] picks [3];
        picks[0] = 4'd2; picks[1] = 4'd9; picks[2] = 4'd4;
        for (int i = 0; i < 10; i++) begin
            wd[i] = DW'($urandom);
            drive_cycle(1'b1, wd[i], 1'b0, '0, 1'b1);
        end
        for (int j = 0; j < 3; j++) begin
            drive_cycle(1'b0, '0, 1'b1, picks[j], 1'b1);
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== wd[picks[j]]) begin n_fail++; $display("FAIL b2b_data[%0d] got v=%0b %0h want v=1 %0h", j, bus.out_valid, bus.out_data, wd[picks[j]]); end
        end
        n_checks++; if (bus.occupancy !== 5'd7) begin n_fail++; $display("FAIL b2b_occ got %0d want 7", bus.occupancy); end
        drive_cycle(1'b0, '0, 1'b0, '0, 1'b1);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 7; i++) drive_cycle(1'b1, DW'(8'h40 + i), 1'b0, '0, 1'b1);
        drive_cycle(1'b0, '0, 1'b1, 4'd0, 1'b0);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.occupancy !== 5'd6) begin n_fail++; $display("FAIL arst_setup got v=%0b occ=%0d want v=1 occ=6", bus.out_valid, bus.occupancy); end
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h77;
        bus.sel_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got %0b want 0", bus.out_valid); end
        n_checks++; if (bus.occupancy !== '0) begin n_fail++; $display("FAIL arst_occ got %0d want 0", bus.occupancy); end
        n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL arst_out_data got %0h want 0", bus.out_data); end
        @(posedge clk);
        #1;
        n_checks++; if (bus.ready_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_pulse got %0b want 0", bus.ready_valid); end
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        model_reset();
        drive_cycle(1'b1, 8'h3C, 1'b0, '0, 1'b1);
        n_checks++; if (bus.ready_valid !== 1'b1 || bus.ready_index !== '0) begin n_fail++; $display("FAIL arst_first_slot got v=%0b idx=%0d want v=1 idx=0", bus.ready_valid, bus.ready_index); end
        drive_cycle(1'b0, '0, 1'b1, 4'd0, 1'b1);
        n_checks++; if (bus.out_data !== 8'h3C) begin n_fail++; $display("FAIL arst_first_data got %0h want 3c", bus.out_data); end
    endtask

    task automatic test_random();
        bit iv, sv, ordy;
        int wr_bias;
        for (int c = 0; c < 400; c++) begin
            wr_bias = ((c / 50) % 2 == 0) ? 80 : 30;
            iv   = ($urandom_range(0, 99) < wr_bias);
            sv   = ($urandom_range(0, 99) < 50);
            ordy = ($urandom_range(0, 99) < 70);
            drive_cycle(iv, DW'($urandom), sv, BB'($urandom), ordy);
            n_checks++; if (obs_in_ready !== e_in_ready) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d got %0b want %0b", c, obs_in_ready, e_in_ready); end
            n_checks++; if (obs_sel_ready !== e_sel_ready) begin n_fail++; $display("FAIL rnd_sel_ready cyc %0d got %0b want %0b", c, obs_sel_ready, e_sel_ready); end
            n_checks++; if (bus.ready_valid !== e_rv || bus.ready_index !== e_ri) begin n_fail++; $display("FAIL rnd_ready cyc %0d got v=%0b idx=%0d want v=%0b idx=%0d", c, bus.ready_valid, bus.ready_index, e_rv, e_ri); end
            n_checks++; if (bus.sel_err !== e_err) begin n_fail++; $display("FAIL rnd_sel_err cyc %0d got %0b want %0b", c, bus.sel_err, e_err); end
            n_checks++; if (bus.out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_out_valid cyc %0d got %0b want %0b", c, bus.out_valid, m_ov); end
            if (m_ov) begin
                n_checks++; if (bus.out_data !== m_od) begin n_fail++; $display("FAIL rnd_out_data cyc %0d got %0h want %0h", c, bus.out_data, m_od); end
            end
            n_checks++; if (bus.occupancy !== (BB + 1)'(m_cnt)) begin n_fail++; $display("FAIL rnd_occ cyc %0d got %0d want %0d", c, bus.occupancy, m_cnt); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_select_backpressure();
        test_simultaneous();
        test_empty_select();
        test_back_to_back();
        test_async_reset();
        apply_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/esm_entry_buffer.md
ESM_ENTRY_BUFFER -- requirements
Module: esm_entry_buffer

Interface
REQ-001 The block SHALL have parameter bs, default 16, meaning number of entry slots (power of two, >= 2).
REQ-002 The block SHALL have parameter dw, default 8, meaning data width per entry; localparam bs_bits = $clog2(bs).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 in_valid  input  1  upstream offers in_data.
REQ-006 in_data  input  dw  entry payload.
REQ-007 in_ready  output  1  slot available; transfer when in_valid && in_ready.
REQ-008 ready_valid  output  1  one-cycle pulse: slot ready_index has just been filled.
REQ-009 ready_index  output  bs_bits  index of slot just filled, feeding the selection core.
REQ-010 sel_valid  input  1  selection core requests slot sel_index.
REQ-011 sel_index  input  bs_bits  slot to emit, i.e. the selection core's buffer_index.
REQ-012 sel_ready  output  1  request accepted when sel_valid && sel_ready.
REQ-013 out_valid  output  1  out_data holds an emitted entry.
REQ-014 out_data  output  dw  emitted payload.
REQ-015 out_ready  input  1  downstream consumes out_data when out_valid && out_ready.
REQ-016 occupancy  output  bs_bits+1  number of filled slots.
REQ-017 sel_err  output  1  one-cycle pulse: accepted request named an empty slot.

Function
REQ-018 Storage SHALL be bs x dw registers plus a bs-bit occupied bitmap.
REQ-019 in_ready SHALL equal (occupancy != bs), combinationally.
- Write rule: on in_valid && in_ready, in_data is written to the lowest-index free slot, computed from the pre-edge bitmap.
- The written slot's occupied bit SHALL be set at the same edge.
REQ-020 ready_valid SHALL pulse high exactly one cycle after the write edge, with ready_index = written slot; otherwise ready_valid = 0 and ready_index holds its last value.
REQ-021 Output stage SHALL be a 2-state FSM: EMPTY (out_valid=0), HOLD (out_valid=1).
- EMPTY->HOLD on an accepted, valid select.
- HOLD->EMPTY on out_ready without a new select.
- HOLD->HOLD on out_ready with a new select, or while out_ready=0.
REQ-022 sel_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-023 Accepted select of an occupied slot SHALL load out_data = mem[sel_index] and clear its occupied bit at the same edge, giving a 1-cycle select-to-out_valid latency.
REQ-024 Accepted select of an empty slot SHALL change no state except sel_err, which pulses for one cycle after the edge.
REQ-025 occupancy SHALL update by +1 (write only), -1 (emit only) or 0 (both or neither) at each edge; it never wraps.
REQ-026 A slot freed by an emit SHALL NOT be chosen for a write in the same cycle; it becomes writable the next cycle.
REQ-027 When full (occupancy = bs), in_ready = 0 and in_data is ignored; a simultaneous emit restores in_ready the next cycle.
REQ-028 out_data SHALL remain stable while out_valid && !out_ready.

Reset
REQ-029 While rst = 0, regardless of clk:
- occupied bitmap = 0, occupancy = 0
- FSM = EMPTY, out_valid = 0, out_data = 0
- ready_valid = 0, ready_index = 0, sel_err = 0
REQ-030 Slot data contents need not be cleared by reset.
REQ-031 Reset asserted mid-transfer SHALL abort it; no ready_valid pulse follows and no in-flight entry is emitted.
REQ-032 The first write after reset release SHALL go to slot 0.

Verification
REQ-033 Fill: write 0xA0..0xAF with bs=16 on consecutive cycles -> ready_index pulses 0..15, one cycle late each; occupancy=16; in_ready=0.
REQ-034 Select/backpressure: slots full, sel_index=5, out_ready=0 -> out_data=0xA5 next cycle and held; sel_ready=0 until out_ready=1; occupancy=15.
REQ-035 Simultaneous: full buffer, same cycle write 0x11 and emit slot 3 -> write refused (in_ready=0); next cycle in_ready=1 and a write of 0x11 fills slot 3.
REQ-036 Empty select: bitmap 0, sel_valid with sel_index=7 -> sel_err pulse, out_valid stays 0, occupancy stays 0.
REQ-037 Back-to-back emits: out_ready=1, selects 2,9,4 on consecutive cycles -> out_data mem[2],mem[9],mem[4] on consecutive cycles; occupancy drops by 3.
REQ-038 Async reset: rst=0 mid-cycle with out_valid=1, occupancy=6 -> out_valid=0 and occupancy=0 immediately; next write after release lands in slot 0.
